// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter (fetch, load/store) for the shared SPI memory engine
// Optional MEM_ARB_TIMEOUT_EN: abort a GRANT that sees no mem_done within TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_is_write,
  input  logic [2:0]  ls_num_bytes,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_error,
  output logic        mem_start,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_num_bytes,
  output logic        mem_is_write,
  output logic [31:0] mem_wdata,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_ls
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_nb_q, mem_nb_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        ls_owner_q, ls_owner_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        pick_ls;
  logic [2:0]  ls_nb_clamped;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       ls_error_q, ls_error_d;
`endif

  assign ls_nb_clamped = (ls_num_bytes == 3'd0 || ls_num_bytes > 3'd4) ? 3'd4 : ls_num_bytes;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_nb_d    = mem_nb_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    ls_owner_d  = ls_owner_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    pick_ls     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    ls_error_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // On contention the requester not served last wins; ls_owner_q doubles as last_ls.
        pick_ls = ls_req && (!if_req || !ls_owner_q);
        if (if_req || ls_req) begin
          ls_owner_d  = pick_ls;
          mem_addr_d  = pick_ls ? ls_addr : if_addr;
          mem_nb_d    = pick_ls ? ls_nb_clamped : 3'd4;
          mem_wr_d    = pick_ls ? ls_is_write : 1'b0;
          mem_wdata_d = pick_ls ? ls_wdata : 32'd0;
          state_d     = GRANT;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      GRANT: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (mem_done) begin
          if (ls_owner_q) begin
            ls_done_d  = 1'b1;
            ls_rdata_d = mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
          state_d = RELEASE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          if (ls_owner_q) begin
            ls_done_d  = 1'b1;
            ls_rdata_d = 32'd0;
            ls_error_d = 1'b1;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = 32'd0;
          end
          state_d = RELEASE;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= 32'd0;
      mem_nb_q    <= 3'd0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      ls_owner_q  <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rdata_q  <= 32'd0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      ls_error_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_nb_q    <= mem_nb_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      ls_owner_q  <= ls_owner_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      ls_error_q  <= ls_error_d;
`endif
    end
  end

  assign mem_start     = (state_q == GRANT);
  assign busy          = (state_q != IDLE);
  assign grant_ls      = ls_owner_q && (state_q == GRANT);
  assign mem_addr      = mem_addr_q;
  assign mem_num_bytes = mem_nb_q;
  assign mem_is_write  = mem_wr_q;
  assign mem_wdata     = mem_wdata_q;
  assign if_done       = if_done_q;
  assign ls_done       = ls_done_q;
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign ls_error      = ls_error_q;
`else
  assign ls_error      = 1'b0;
`endif

endmodule
